// File: rtl/compressed_fetch_ctrl.sv
// Fetch controller for a mixed 16/32-bit instruction stream: fetches aligned words
// into a 4-halfword queue and issues compressed or full-width instructions to decode.
module compressed_fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic [15:0] exp_in,
  input  logic [31:0] exp_out,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  output logic        inst_is_c,
  output logic [1:0]  fsm_state
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WAIT = 2'd1;
  localparam logic [1:0] DROP = 2'd2;

  logic [1:0]  state;
  logic [63:0] q;          // halfword queue, head in [15:0]; slots past count are kept zero
  logic [2:0]  count;
  logic [31:0] pc;
  logic [31:0] fetch_pc;
  logic [31:0] req_addr;
  logic        skip_lo;

  logic        head_c;
  logic        fire;
  logic        push;
  logic [2:0]  pop_n;
  logic [2:0]  push_n;
  logic [2:0]  kept;
  logic [31:0] push_data;
  logic [63:0] q_next;
  logic [2:0]  count_next;

  // Handshakes: imem_req is held with a stable imem_addr until imem_ack; an
  // instruction transfers on inst_valid && inst_ready, and inst/inst_pc/inst_is_c
  // hold while inst_valid is high and inst_ready is low.
  always_comb begin
    head_c     = (q[1:0] != 2'b11);
    inst_valid = !redirect && ((count >= 3'd1 && head_c) || (count >= 3'd2 && !head_c));
    fire       = inst_valid && inst_ready;
    pop_n      = fire ? (head_c ? 3'd1 : 3'd2) : 3'd0;
    push       = (state == WAIT) && imem_ack && !redirect;
    push_n     = !push ? 3'd0 : (skip_lo ? 3'd1 : 3'd2);
    push_data  = skip_lo ? {16'h0000, imem_rdata[31:16]} : imem_rdata;
    kept       = count - pop_n;
    q_next     = q >> {pop_n, 4'b0000};
    if (push) begin
      q_next = q_next | ({32'h0000_0000, push_data} << {kept, 4'b0000});
    end
    count_next = kept + push_n;
  end

  assign exp_in    = q[15:0];
  assign inst      = !inst_valid ? 32'h0000_0000 : (head_c ? exp_out : q[31:0]);
  assign inst_is_c = inst_valid && head_c;
  assign inst_pc   = pc;
  assign imem_req  = (state != IDLE);
  assign imem_addr = (state == IDLE) ? fetch_pc : req_addr;
  assign fsm_state = state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      q        <= 64'h0;
      count    <= 3'd0;
      pc       <= RESET_PC;
      fetch_pc <= {RESET_PC[31:2], 2'b00};
      req_addr <= {RESET_PC[31:2], 2'b00};
      skip_lo  <= RESET_PC[1];
    end else begin
      if (redirect) begin
        q        <= 64'h0;
        count    <= 3'd0;
        pc       <= redirect_pc;
        fetch_pc <= {redirect_pc[31:2], 2'b00};
        skip_lo  <= redirect_pc[1];
      end else begin
        q     <= q_next;
        count <= count_next;
        if (fire) pc <= pc + (head_c ? 32'd2 : 32'd4);
        if (push) begin
          fetch_pc <= fetch_pc + 32'd4;
          skip_lo  <= 1'b0;
        end
      end
      // A fetch only starts when the queue can absorb a full word.
      case (state)
        IDLE: if (!redirect && count <= 3'd2) begin
          state    <= WAIT;
          req_addr <= fetch_pc;
        end
        WAIT: begin
          if (imem_ack) state <= IDLE;
          else if (redirect) state <= DROP;
        end
        DROP: if (imem_ack) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/compressed_fetch_ctrl.md
COMPRESSED_FETCH_CTRL -- requirements
Module: compressed_fetch_ctrl

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the byte address of the first instruction after reset (halfword aligned).
REQ-002 SHALL have port clk  input  1  sole clock; all state on rising edge.
REQ-003 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port imem_req  output  1  fetch request, held until imem_ack.
REQ-005 SHALL have port imem_addr  output  32  word-aligned fetch byte address, bits [1:0]=00.
REQ-006 SHALL have port imem_ack  input  1  imem_rdata valid this cycle; may assert in the same cycle imem_req rises.
REQ-007 SHALL have port imem_rdata  input  32  fetched word, little-endian halfwords.
REQ-008 SHALL have port redirect  input  1  pipeline flush / control transfer.
REQ-009 SHALL have port redirect_pc  input  32  new PC, halfword aligned.
REQ-010 SHALL have port exp_in  output  16  halfword driven to the compressed-instruction expander.
REQ-011 SHALL have port exp_out  input  32  expander result, combinational from exp_in.
REQ-012 SHALL have ports inst_valid output 1, inst_ready input 1, inst output 32, inst_pc output 32, inst_is_c output 1: issue handshake toward decode.

Function
REQ-013 SHALL hold a halfword queue of capacity 4 (count 0..4), head at the lowest address.
REQ-014 SHALL implement FSM IDLE (no fetch outstanding), WAIT (fetch outstanding, response kept), DROP (fetch outstanding, response discarded).
REQ-015 IDLE -> WAIT, imem_req=1, when count<=2 and no redirect; imem_addr=fetch_pc; addr and req stable until ack.
REQ-016 WAIT on imem_ack: push halfwords, fetch_pc+=4, -> IDLE; a new request is allowed no earlier than the following cycle.
REQ-017 SHALL push both halfwords normally; push only imem_rdata[31:16] when skip_lo is set, then clear skip_lo.
REQ-018 Head classification: head[1:0]!=2'b11 -> compressed; else 32-bit.
REQ-019 inst_valid=1 when count>=1 and compressed, or count>=2 and 32-bit; 0 during a redirect cycle.
REQ-020 exp_in=queue head always; compressed: inst=exp_out, inst_is_c=1; 32-bit: inst={head+1,head}, inst_is_c=0; inst=0 when inst_valid=0.
REQ-021 inst_pc=pc register; on inst_valid&&inst_ready pop 1 (pc+=2) or 2 (pc+=4) halfwords.
REQ-022 inst, inst_pc, inst_is_c SHALL remain stable while inst_valid&&!inst_ready.
REQ-023 Same-cycle push and pop SHALL both apply: count_next=count+pushed-popped, never exceeding 4.
REQ-024 redirect (highest priority): flush queue (count=0), pc=redirect_pc, fetch_pc={redirect_pc[31:2],2'b00}, skip_lo=redirect_pc[1], no pop, no push.
REQ-025 redirect in WAIT without ack -> DROP; with ack in same cycle -> IDLE, data discarded; in IDLE -> IDLE.
REQ-026 DROP: imem_req stays 1 with old address until ack; on ack discard data, -> IDLE; further redirect in DROP updates pc/fetch_pc/skip_lo only.
REQ-027 imem_ack in IDLE SHALL be ignored.
REQ-028 Arithmetic modulo 2^32; fetch_pc wraps 0xFFFF_FFFC -> 0x0000_0000.

Reset
REQ-029 While rst=1 (asynchronously): state=IDLE, imem_req=0, count=0, inst_valid=0, inst=0, pc=RESET_PC, fetch_pc=RESET_PC&~3, imem_addr=fetch_pc, skip_lo=RESET_PC[1].
REQ-030 An ack for a request aborted by reset SHALL be ignored; first request issues in the first cycle after rst deasserts.

Verification
REQ-031 Reset release, RESET_PC=0, ack 0x45014501 -> req addr 0x0; next cycles issue exp_in=0x4501, inst_is_c=1 at inst_pc 0x0 then 0x2.
REQ-032 Straddle: word@0=0x00134501, word@4=0x45010000 -> issue pc0x0 C; pc0x2 inst=0x00000013 inst_is_c=0 only after second ack; pc0x6 C.
REQ-033 redirect to 0x102 in WAIT, ack next cycle -> data dropped; next req addr 0x100; low half discarded; first inst_pc=0x102.
REQ-034 inst_ready=0 for 10 cycles with acks of 0x45014501 -> outputs stable, count reaches 4, imem_req stays 0 while count>2.
REQ-035 redirect, imem_ack, inst_ready, inst_valid same cycle -> no issue, count=0, next imem_addr={redirect_pc[31:2],00}.
REQ-036 rst pulse while imem_req=1, late ack afterward -> imem_req drops immediately, late ack ignored, fetch restarts at RESET_PC&~3.
